// File: rtl/a2d_rr_sched.sv
// Round-robin conversion scheduler for the shared A2D SPI link: a command transaction,
// then a read transaction per trigger, with per-channel result registers and a watchdog.
module a2d_rr_sched #(
  parameter int TIMEOUT = 4096,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        upd_vld,
  output logic [1:0]  upd_ch,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CNV  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] RD   = 2'd3;

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [GP_W-1:0] GP_LD  = GP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  logic [1:0]      state;
  logic [1:0]      rr;
  logic            pending;
  logic [WD_W-1:0] wdog;
  logic [GP_W-1:0] gap;
  logic            wd_hit;
  logic            unused_resp;

  assign wd_hit      = (wdog == WD_MAX);
  assign unused_resp = ^resp[15:12];

  // rr -> ADC channel: 0 lft(ch0), 1 rght(ch4), 2 steer(ch5), 3 batt(ch6)
  function automatic logic [15:0] rr_cmd(input logic [1:0] r);
    logic [2:0] ch;
    case (r)
      2'd0:    ch = 3'd0;
      2'd1:    ch = 3'd4;
      2'd2:    ch = 3'd5;
      default: ch = 3'd6;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 2'd0;
      pending   <= 1'b0;
      wdog      <= '0;
      gap       <= '0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      upd_vld   <= 1'b0;
      upd_ch    <= 2'd0;
      busy      <= 1'b0;
      err       <= 1'b0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      wrt     <= 1'b0;
      upd_vld <= 1'b0;
      // one-deep trigger memory; covers the cycle RD hands back to IDLE
      if (nxt && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: if (nxt || pending) begin
          pending <= 1'b0;
          wrt     <= 1'b1;
          cmd     <= rr_cmd(rr);
          wdog    <= '0;
          busy    <= 1'b1;
          state   <= CNV;
        end
        CNV: if (done) begin
          gap   <= GP_LD;
          state <= GAP;
        end else if (wd_hit) begin
          err   <= 1'b1;
          rr    <= rr + 2'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          wdog <= wdog + 1'b1;
        end
        GAP: if (gap == '0) begin
          wrt   <= 1'b1;
          wdog  <= '0;
          state <= RD;
        end else begin
          gap <= gap - 1'b1;
        end
        default: if (done) begin
          case (rr)
            2'd0:    lft_ld    <= resp[11:0];
            2'd1:    rght_ld   <= resp[11:0];
            2'd2:    steer_pot <= resp[11:0];
            default: batt      <= resp[11:0];
          endcase
          upd_vld <= 1'b1;
          upd_ch  <= rr;
          rr      <= rr + 2'd1;
          busy    <= 1'b0;
          state   <= IDLE;
        end else if (wd_hit) begin
          err   <= 1'b1;
          rr    <= rr + 2'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          wdog <= wdog + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Bench for a2d_rr_sched: SPI master model fed from a transaction queue, table vectors,
// hand-written timeout/reset sequences and random bursts against a transaction-level model.
module tb_a2d_rr_sched;
  localparam int TIMEOUT = 64;
  localparam int GAP_CYC = 2;

  logic        clk = 1'b0, rst = 1'b1, nxt = 1'b0, done = 1'b0;
  logic [15:0] resp = 16'h0;
  logic        wrt, upd_vld, busy, err;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic [1:0]  upd_ch;

  a2d_rr_sched #(.TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done), .resp(resp),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .upd_vld(upd_vld), .upd_ch(upd_ch), .busy(busy), .err(err));

  always #5 clk = ~clk;

  typedef struct { bit mute; int lat; logic [15:0] data; } xact_t;
  typedef struct { logic [15:0] cmd; int cyc; } wev_t;
  typedef struct { logic [1:0] ch; logic [11:0] val; } uev_t;
  typedef struct { logic [15:0] rsp; int lc; int lr;
                   logic [15:0] exp_cmd; logic [1:0] exp_ch; logic [11:0] exp_val; } vec_t;

  int n_cmp = 0, n_err = 0, cyc = 0;
  xact_t xq[$];
  wev_t  wq[$];
  uev_t  uq[$];
  int          mrr = 0;
  logic [11:0] mreg [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] dut_reg(input logic [1:0] c);
    case (c)
      2'd0:    return lft_ld;
      2'd1:    return rght_ld;
      2'd2:    return steer_pot;
      default: return batt;
    endcase
  endfunction

  // channel map from the datasheet ordering: lft ch0, rght ch4, steer ch5, batt ch6
  function automatic logic [15:0] chan_cmd(input int r);
    int ch;
    ch = (r % 4 == 0) ? 0 : (r % 4) + 3;
    return 16'(ch * 2048);
  endfunction

  // SPI master model: each wrt consumes one queued transaction and answers after lat cycles
  xact_t cur;
  bit    act = 1'b0;
  int    cd = 0;
  always @(negedge clk) begin
    done = 1'b0;
    resp = 16'($urandom);
    if (act) begin
      if (cd == 0) begin done = 1'b1; resp = cur.data; act = 1'b0; end
      else cd--;
    end
    if (wrt) begin
      if (xq.size() > 0) cur = xq.pop_front();
      else begin cur.mute = 1'b0; cur.lat = 2; cur.data = 16'($urandom); end
      if (!cur.mute) begin act = 1'b1; cd = cur.lat - 1; end
    end
  end

  // event monitor
  always @(negedge clk) begin
    if (wrt) wq.push_back('{cmd, cyc});
    if (upd_vld) uq.push_back('{upd_ch, dut_reg(upd_ch)});
    if (wrt || upd_vld) chk("wrt_upd_exclusive", 32'(wrt && upd_vld), 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_quiet(input int budget);
    int q = 0, n = 0;
    while (q < 3 && n < budget) begin
      @(negedge clk);
      n++;
      q = busy ? 0 : q + 1;
    end
    chk("idle_within_budget", 32'(q >= 3), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    mrr = 0;
    foreach (mreg[i]) mreg[i] = 12'h000;
    xq.delete();
    tick(1);
  endtask

  task automatic chk_regs();
    chk("lft_ld", 32'(lft_ld), 32'(mreg[0]));
    chk("rght_ld", 32'(rght_ld), 32'(mreg[1]));
    chk("steer_pot", 32'(steer_pot), 32'(mreg[2]));
    chk("batt", 32'(batt), 32'(mreg[3]));
  endtask

  // k back-to-back nxt cycles from idle: first starts, second goes pending, rest dropped
  task automatic run_burst(input int k, input logic [15:0] d0, input logic [15:0] d1,
                           input int lc, input int lr);
    int nconv, t0, sep;
    logic [15:0] d [2];
    d[0] = d0; d[1] = d1;
    nconv = (k >= 2) ? 2 : 1;
    for (int i = 0; i < nconv; i++) begin
      xq.push_back('{1'b0, lc, 16'hDEAD ^ 16'(i)});
      xq.push_back('{1'b0, lr, d[i]});
    end
    wq.delete(); uq.delete();
    nxt = 1'b1; t0 = cyc;
    tick(k);
    nxt = 1'b0;
    wait_quiet(400);
    tick(2);
    chk("wrt_count", 32'(wq.size()), 32'(2 * nconv));
    chk("upd_count", 32'(uq.size()), 32'(nconv));
    if (wq.size() > 0) chk("nxt_to_wrt_latency", 32'(wq[0].cyc - t0), 32'd1);
    for (int i = 0; i < nconv; i++) begin
      if (wq.size() == 2 * nconv) begin
        chk("cmd_first", 32'(wq[2*i].cmd), 32'(chan_cmd(mrr)));
        chk("cmd_second", 32'(wq[2*i+1].cmd), 32'(chan_cmd(mrr)));
        sep = wq[2*i+1].cyc - wq[2*i].cyc;
        chk("gap_spacing", 32'(sep >= lc + GAP_CYC + 1 && sep <= lc + GAP_CYC + 2), 32'd1);
      end
      if (uq.size() == nconv) begin
        chk("upd_ch", 32'(uq[i].ch), 32'(mrr % 4));
        chk("upd_val", 32'(uq[i].val), 32'(d[i][11:0]));
      end
      mreg[mrr % 4] = d[i][11:0];
      mrr++;
    end
    chk_regs();
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  vec_t vt [6];
  int w;

  initial begin
    vt[0] = '{16'h0ABC, 1, 1, 16'h0000, 2'd0, 12'hABC};
    vt[1] = '{16'h0222, 2, 3, 16'h2000, 2'd1, 12'h222};
    vt[2] = '{16'h0333, 3, 1, 16'h2800, 2'd2, 12'h333};
    vt[3] = '{16'h0444, 1, 4, 16'h3000, 2'd3, 12'h444};
    vt[4] = '{16'hF7FF, 2, 2, 16'h0000, 2'd0, 12'h7FF};
    vt[5] = '{16'h5123, 5, 1, 16'h2000, 2'd1, 12'h123};

    do_reset();
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_upd_vld", 32'(upd_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_upd_ch", 32'(upd_ch), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk_regs();

    // table vectors: round-robin order, wrap, upper nibble discarded
    for (int i = 0; i < 6; i++) begin
      run_burst(1, vt[i].rsp, 16'h0, vt[i].lc, vt[i].lr);
      if (wq.size() > 0) chk("tbl_cmd", 32'(wq[0].cmd), 32'(vt[i].exp_cmd));
      if (uq.size() > 0) begin
        chk("tbl_ch", 32'(uq[0].ch), 32'(vt[i].exp_ch));
        chk("tbl_val", 32'(uq[0].val), 32'(vt[i].exp_val));
      end
    end

    // watchdog: command transaction never completes
    do_reset();
    xq.push_back('{1'b1, 0, 16'h0});
    wq.delete(); uq.delete();
    nxt = 1'b1; tick(1); nxt = 1'b0;
    for (int n = 0; n < 10 && wq.size() == 0; n++) tick(1);
    chk("wd_wrt_seen", 32'(wq.size()), 32'd1);
    w = (wq.size() > 0) ? wq[0].cyc : cyc;
    while (cyc < w + TIMEOUT - 1) tick(1);
    chk("wd_err_before", 32'(err), 32'd0);
    tick(1);
    chk("wd_err_at_timeout", 32'(err), 32'd1);
    chk("wd_busy_dropped", 32'(busy), 32'd0);
    tick(3);
    chk("wd_no_upd", 32'(uq.size()), 32'd0);
    chk("wd_no_read_wrt", 32'(wq.size()), 32'd1);
    chk_regs();
    mrr++;
    run_burst(1, 16'h0555, 16'h0, 2, 2);
    chk("wd_err_sticky", 32'(err), 32'd1);

    // three triggers during one conversion: two conversions complete
    run_burst(3, 16'h0A5A, 16'h0C3C, 2, 3);

    // reset while in RD, the late done must be ignored
    do_reset();
    xq.push_back('{1'b0, 1, 16'hDEAD});
    xq.push_back('{1'b0, 12, 16'h0999});
    wq.delete(); uq.delete();
    nxt = 1'b1; tick(1); nxt = 1'b0;
    for (int n = 0; n < 30 && wq.size() < 2; n++) tick(1);
    chk("rst_rd_reached", 32'(wq.size()), 32'd2);
    tick(2);
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(15);
    chk("rst_rd_no_upd", 32'(uq.size()), 32'd0);
    chk("rst_rd_busy", 32'(busy), 32'd0);
    chk("rst_rd_err", 32'(err), 32'd0);
    chk_regs();
    run_burst(1, 16'h0321, 16'h0, 1, 1);

    // random bursts
    for (int it = 0; it < 40; it++)
      run_burst(int'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
                int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
